asynchronous_fifo_write_controller: RTL and testbench

ASYNCHRONOUS_FIFO_WRITE_CONTROLLER -- requirements
Module: asynchronous_fifo_write_controller

---
 rtl/asynchronous_fifo_write_controller.sv | 76 +++++++
 tb/tb_asynchronous_fifo_write_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/asynchronous_fifo_write_controller.sv
// rtl/asynchronous_fifo_write_controller.sv - write-domain half of a dual-clock FIFO
module asynchronous_fifo_write_controller #(
  parameter int DATA_WIDTH            = 16,
  parameter int DATA_DEPTH            = 4096,
  parameter int ALMOST_FULL_THRESHOLD = DATA_DEPTH - 16,
  localparam int AW                   = $clog2(DATA_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [AW-1:0]         read_pointer_gray,
  output logic                  memory_write_enable,
  output logic [AW-1:0]         memory_write_address,
  output logic [DATA_WIDTH-1:0] memory_write_data,
  output logic [AW-1:0]         write_pointer_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [AW-1:0]         fill_level,
  output logic                  overflow
);

  localparam logic [AW-1:0] ONE          = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   AF_THRESHOLD = (AW+1)'(ALMOST_FULL_THRESHOLD);

  logic [AW-1:0] write_pointer;
  logic [AW-1:0] next_write_pointer;
  logic [AW-1:0] next_fill;
  logic [AW-1:0] read_sync_1;
  logic [AW-1:0] read_sync_2;
  logic [AW-1:0] rd_sync;
  logic          accept;

  assign accept               = reset_n && write_enable && !full;
  assign memory_write_enable  = accept;
  assign memory_write_address = write_pointer;
  assign memory_write_data    = write_data;
  assign next_write_pointer   = accept ? write_pointer + ONE : write_pointer;
  assign next_fill            = next_write_pointer - rd_sync;

  // Gray-to-binary: each bit is the XOR of all Gray bits at and above it.
  always_comb begin
    rd_sync = '0;
    rd_sync[AW-1] = read_sync_2[AW-1];
    for (int i = AW - 2; i >= 0; i--) begin
      rd_sync[i] = rd_sync[i+1] ^ read_sync_2[i];
    end
  end

  // Flags use the post-write pointer and a lagging read pointer, so they can
  // only err on the pessimistic side; one slot is kept empty to separate full from empty.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      write_pointer      <= '0;
      write_pointer_gray <= '0;
      read_sync_1        <= '0;
      read_sync_2        <= '0;
      full               <= 1'b0;
      almost_full        <= 1'b0;
      fill_level         <= '0;
      overflow           <= 1'b0;
    end else begin
      write_pointer      <= next_write_pointer;
      write_pointer_gray <= next_write_pointer ^ (next_write_pointer >> 1);
      read_sync_1        <= read_pointer_gray;
      read_sync_2        <= read_sync_1;
      full               <= (next_write_pointer + ONE) == rd_sync;
      almost_full        <= {1'b0, next_fill} >= AF_THRESHOLD;
      fill_level         <= next_fill;
      if (write_enable && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_asynchronous_fifo_write_controller.sv
// tb/tb_asynchronous_fifo_write_controller.sv - directed bench for asynchronous_fifo_write_controller
module tb_asynchronous_fifo_write_controller;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          write_enable;
  logic [DW-1:0] write_data;
  logic [AW-1:0] read_pointer_gray;
  logic          memory_write_enable;
  logic [AW-1:0] memory_write_address;
  logic [DW-1:0] memory_write_data;
  logic [AW-1:0] write_pointer_gray;
  logic          full;
  logic          almost_full;
  logic [AW-1:0] fill_level;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  asynchronous_fifo_write_controller #(
    .DATA_WIDTH(DW),
    .DATA_DEPTH(8),
    .ALMOST_FULL_THRESHOLD(6)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .write_enable(write_enable),
    .write_data(write_data),
    .read_pointer_gray(read_pointer_gray),
    .memory_write_enable(memory_write_enable),
    .memory_write_address(memory_write_address),
    .memory_write_data(memory_write_data),
    .write_pointer_gray(write_pointer_gray),
    .full(full),
    .almost_full(almost_full),
    .fill_level(fill_level),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [AW-1:0] to_gray(input logic [AW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [AW-1:0] gray_table [7];
  logic [AW-1:0] model_pointer;
  logic [AW-1:0] prev_gray;

  initial begin
    gray_table = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

    // Reset held with a pending write
    reset_n = 1'b0; write_enable = 1'b1; write_data = 16'h1234; read_pointer_gray = '0;
    tick(); tick();
    check("reset_mem_we", 32'(memory_write_enable), 32'd0);
    check("reset_gray", 32'(write_pointer_gray), 32'd0);
    check("reset_full", 32'(full), 32'd0);
    check("reset_almost_full", 32'(almost_full), 32'd0);
    check("reset_fill", 32'(fill_level), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_addr", 32'(memory_write_address), 32'd0);
    reset_n = 1'b1;

    // Fill to capacity with the read side idle
    for (int k = 0; k < 7; k++) begin
      write_enable = 1'b1; write_data = 16'(16'hA0 + k);
      #1;
      check("fill_mem_we", 32'(memory_write_enable), 32'd1);
      check("fill_addr", 32'(memory_write_address), 32'(k));
      check("fill_data", 32'(memory_write_data), 32'(16'hA0 + k));
      tick();
      check("fill_gray", 32'(write_pointer_gray), 32'(gray_table[k]));
      if (k == 4) check("fill_af_before", 32'(almost_full), 32'd0);
      if (k == 5) check("fill_af_6th", 32'(almost_full), 32'd1);
      if (k == 5) check("fill_full_6th", 32'(full), 32'd0);
    end
    check("fill_full_7th", 32'(full), 32'd1);
    check("fill_level_7th", 32'(fill_level), 32'd7);

    // Write attempt while full is dropped and latches overflow
    write_enable = 1'b1; write_data = 16'hDEAD;
    #1;
    check("ovf_mem_we", 32'(memory_write_enable), 32'd0);
    tick();
    check("ovf_gray_held", 32'(write_pointer_gray), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_full", 32'(full), 32'd1);

    // Read side advances to 2; visible after exactly three edges
    write_enable = 1'b0; read_pointer_gray = 3'b011;
    tick();
    check("drain_full_e1", 32'(full), 32'd1);
    tick();
    check("drain_full_e2", 32'(full), 32'd1);
    tick();
    check("drain_full_e3", 32'(full), 32'd0);
    check("drain_fill_e3", 32'(fill_level), 32'd5);
    check("drain_af_e3", 32'(almost_full), 32'd0);
    write_enable = 1'b1; write_data = 16'h0B07;
    #1;
    check("drain_w1_we", 32'(memory_write_enable), 32'd1);
    check("drain_w1_addr", 32'(memory_write_address), 32'd7);
    tick();
    check("drain_w1_fill", 32'(fill_level), 32'd6);
    check("drain_w1_full", 32'(full), 32'd0);
    write_data = 16'h0B00;
    #1;
    check("drain_w2_we", 32'(memory_write_enable), 32'd1);
    check("drain_w2_addr", 32'(memory_write_address), 32'd0);
    tick();
    check("drain_w2_full", 32'(full), 32'd1);
    check("drain_w2_fill", 32'(fill_level), 32'd7);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Read side catches up completely
    write_enable = 1'b0; read_pointer_gray = to_gray(3'd1);
    tick(); tick(); tick();
    check("catchup_full", 32'(full), 32'd0);
    check("catchup_fill", 32'(fill_level), 32'd0);

    // Wrap: 20 writes with the reader tracking
    model_pointer = 3'd1;
    prev_gray = write_pointer_gray;
    for (int k = 0; k < 20; k++) begin
      read_pointer_gray = to_gray(model_pointer);
      write_enable = 1'b1; write_data = 16'(k);
      #1;
      check("wrap_mem_we", 32'(memory_write_enable), 32'd1);
      check("wrap_addr", 32'(memory_write_address), 32'(model_pointer));
      tick();
      model_pointer = model_pointer + 3'd1;
      check("wrap_gray", 32'(write_pointer_gray), 32'(to_gray(model_pointer)));
      check("wrap_one_bit", 32'($countones(write_pointer_gray ^ prev_gray)), 32'd1);
      prev_gray = write_pointer_gray;
    end

    // Four more writes, then a one-cycle reset mid-operation
    for (int k = 0; k < 4; k++) begin
      read_pointer_gray = to_gray(model_pointer);
      write_enable = 1'b1;
      tick();
      model_pointer = model_pointer + 3'd1;
    end
    check("pre_reset_gray", 32'(write_pointer_gray), 32'(to_gray(model_pointer)));
    reset_n = 1'b0; read_pointer_gray = '0; write_enable = 1'b1;
    #1;
    check("mid_reset_mem_we", 32'(memory_write_enable), 32'd0);
    tick();
    check("mid_reset_gray", 32'(write_pointer_gray), 32'd0);
    check("mid_reset_addr", 32'(memory_write_address), 32'd0);
    check("mid_reset_fill", 32'(fill_level), 32'd0);
    check("mid_reset_overflow", 32'(overflow), 32'd0);
    check("mid_reset_full", 32'(full), 32'd0);
    reset_n = 1'b1;
    #1;
    check("post_reset_we", 32'(memory_write_enable), 32'd1);
    check("post_reset_addr", 32'(memory_write_address), 32'd0);
    tick();
    check("post_reset_gray", 32'(write_pointer_gray), 32'd1);
    check("post_reset_fill", 32'(fill_level), 32'd1);
    write_enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
